multi_cycle_alu: RTL

MULTI_CYCLE_ALU -- requirements
Module: multi_cycle_alu

---
 rtl/alu_pkg.sv | 36 +++
 rtl/mul_div_iter.sv | 111 +++++++++++
 rtl/multi_cycle_alu.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the multi-cycle ALU:
//   - 6-bit function codes accepted on the Signal port
//   - FSM state encoding used by multi_cycle_alu
//   - a small helper that classifies a function code as multi-cycle
// -----------------------------------------------------------------------------
package alu_pkg;

  // Function codes (MIPS-style funct field values)
  localparam logic [5:0] FN_SRL   = 6'd2;
  localparam logic [5:0] FN_MFHI  = 6'd16;
  localparam logic [5:0] FN_MFLO  = 6'd18;
  localparam logic [5:0] FN_MULTU = 6'd25;
  localparam logic [5:0] FN_DIVU  = 6'd27;
  localparam logic [5:0] FN_ADD   = 6'd32;
  localparam logic [5:0] FN_SUB   = 6'd34;
  localparam logic [5:0] FN_AND   = 6'd36;
  localparam logic [5:0] FN_OR    = 6'd37;
  localparam logic [5:0] FN_SLT   = 6'd42;

  // Controller states. MUL/DIV iterate one bit per cycle; FIN is the single
  // cycle in which the new Hi/Lo and the done pulse are visible.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIN  = 2'd3
  } state_e;

  // True for codes that run through the iterative datapath.
  function automatic logic is_multi_cycle(input logic [5:0] fn);
    return (fn == FN_MULTU) || (fn == FN_DIVU);
  endfunction

endpackage

// File: rtl/mul_div_iter.sv
// -----------------------------------------------------------------------------
// mul_div_iter
// One-bit-per-cycle iteration datapath shared by unsigned multiply
// (right-shifting shift-add) and unsigned division (restoring).
//
// Ports:
//   clk      in   clock, rising edge
//   reset    in   asynchronous active-low reset
//   load     in   capture op_a/op_b and clear the accumulator/counter
//   step     in   perform one iteration using the mode given by is_div
//   is_div   in   0: multiply step, 1: divide step
//   op_a     in   multiplier / dividend
//   op_b     in   multiplicand / divisor
//   res_hi   out  accumulator value after the current step
//                 (product upper half / remainder)
//   res_lo   out  shift register value after the current step
//                 (product lower half / quotient)
//   last     out  the current step is the final (WIDTH-th) one
//
// res_hi/res_lo are the combinational next-state values so the controller
// can capture the finished result on the same edge as the final step.
// -----------------------------------------------------------------------------
module mul_div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             last
);

  // Counter must be able to hold WIDTH itself after the final increment.
  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] acc_nx;
  logic [WIDTH-1:0] sh_nx;

  always_comb begin
    // Multiply: {acc, sh} holds partial product / remaining multiplier bits.
    // Add the multiplicand when the current multiplier LSB is set, then shift
    // the whole WIDTH*2+1 value right by one.
    mul_sum = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});

    // Divide: bring the next dividend bit into the partial remainder and
    // subtract the divisor if it fits. The remainder stays < divisor, so the
    // shifted value needs one extra bit but the result fits in WIDTH bits,
    // which is why only the low WIDTH bits of the difference are kept.
    div_shift = {acc_q, sh_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opb_q});
    div_diff  = div_shift[WIDTH-1:0] - opb_q;

    if (is_div) begin
      acc_nx = div_ge ? div_diff : div_shift[WIDTH-1:0];
      sh_nx  = {sh_q[WIDTH-2:0], div_ge};
    end else begin
      acc_nx = mul_sum[WIDTH:1];
      sh_nx  = {mul_sum[0], sh_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    acc_d = acc_q;
    sh_d  = sh_q;
    opb_d = opb_q;
    cnt_d = cnt_q;
    if (load) begin
      acc_d = '0;
      sh_d  = op_a;
      opb_d = op_b;
      cnt_d = '0;
    end else if (step) begin
      acc_d = acc_nx;
      sh_d  = sh_nx;
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
      sh_q  <= '0;
      opb_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      sh_q  <= sh_d;
      opb_q <= opb_d;
      cnt_q <= cnt_d;
    end
  end

  assign res_hi = acc_nx;
  assign res_lo = sh_nx;
  assign last   = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/multi_cycle_alu.sv
// -----------------------------------------------------------------------------
// multi_cycle_alu
// MIPS-flavoured ALU with single-cycle logic/arithmetic/shift ops and
// WIDTH-cycle MULTU/DIVU writing a Hi/Lo register pair.
//
// Ports:
//   clk       in   clock, rising edge
//   reset     in   asynchronous active-low reset
//   start     in   request; sampled only while busy=0
//   Signal    in   6-bit function code (see alu_pkg)
//   dataA     in   operand A
//   dataB     in   operand B (SRL uses dataB[SHW-1:0] as the shift amount)
//   busy      out  high from the edge after a MULTU/DIVU start through FIN
//   done      out  one-cycle result-valid pulse
//   Output    out  registered result, held until the next done
//   div_zero  out  sticky divide-by-zero flag, cleared by an accepted start
//   illegal   out  high with done for an unsupported function code
//
// Timing: single-cycle ops update Output on the accepting edge and done is
// high in the following cycle. Multi-cycle ops iterate WIDTH cycles; the
// final iteration edge moves to FIN and captures Hi/Lo/Output/done together,
// so done appears WIDTH+1 cycles after the start cycle.
// -----------------------------------------------------------------------------
module multi_cycle_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       Signal,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Output,
  output logic             div_zero,
  output logic             illegal
);

  import alu_pkg::*;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] output_q, output_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             illegal_q, illegal_d;
  logic             div_zero_q, div_zero_d;
  // Dividend and zero-divisor flag are kept so a divide by zero can report
  // the architecturally defined Hi/Lo instead of the raw iteration result.
  logic [WIDTH-1:0] dividend_q, dividend_d;
  logic             dz_pend_q, dz_pend_d;

  logic             accept;
  logic             iter_load;
  logic             iter_step;
  logic             iter_is_div;
  logic [WIDTH-1:0] iter_hi;
  logic [WIDTH-1:0] iter_lo;
  logic             iter_last;
  logic             slt_lt;

  assign accept      = start && (state_q == IDLE);
  assign iter_is_div = (state_q == DIV);
  assign slt_lt      = ($signed(dataA) < $signed(dataB));

  mul_div_iter #(
    .WIDTH (WIDTH)
  ) u_iter (
    .clk    (clk),
    .reset  (reset),
    .load   (iter_load),
    .step   (iter_step),
    .is_div (iter_is_div),
    .op_a   (dataA),
    .op_b   (dataB),
    .res_hi (iter_hi),
    .res_lo (iter_lo),
    .last   (iter_last)
  );

  // Next-state and datapath control
  always_comb begin
    state_d    = state_q;
    output_d   = output_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    illegal_d  = 1'b0;
    div_zero_d = div_zero_q;
    dividend_d = dividend_q;
    dz_pend_d  = dz_pend_q;
    iter_load  = 1'b0;
    iter_step  = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          div_zero_d = 1'b0;
          if (is_multi_cycle(Signal)) begin
            iter_load = 1'b1;
            if (Signal == FN_DIVU) begin
              state_d    = DIV;
              dividend_d = dataA;
              dz_pend_d  = (dataB == '0);
            end else begin
              state_d    = MUL;
              dz_pend_d  = 1'b0;
            end
          end else begin
            done_d = 1'b1;
            case (Signal)
              FN_AND:  output_d = dataA & dataB;
              FN_OR:   output_d = dataA | dataB;
              FN_ADD:  output_d = dataA + dataB;
              FN_SUB:  output_d = dataA - dataB;
              FN_SLT:  output_d = {{(WIDTH-1){1'b0}}, slt_lt};
              FN_SRL:  output_d = dataA >> dataB[SHW-1:0];
              FN_MFHI: output_d = hi_q;
              FN_MFLO: output_d = lo_q;
              default: begin
                output_d  = '0;
                illegal_d = 1'b1;
              end
            endcase
          end
        end
      end

      MUL, DIV: begin
        iter_step = 1'b1;
        if (iter_last) begin
          state_d = FIN;
          done_d  = 1'b1;
          if ((state_q == DIV) && dz_pend_q) begin
            hi_d       = dividend_q;
            lo_d       = '1;
            div_zero_d = 1'b1;
          end else begin
            hi_d = iter_hi;
            lo_d = iter_lo;
          end
          output_d = lo_d;
        end
      end

      FIN: begin
        // busy is still high here, so any start this cycle is dropped.
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      output_q   <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      illegal_q  <= 1'b0;
      div_zero_q <= 1'b0;
      dividend_q <= '0;
      dz_pend_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      output_q   <= output_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      illegal_q  <= illegal_d;
      div_zero_q <= div_zero_d;
      dividend_q <= dividend_d;
      dz_pend_q  <= dz_pend_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign Output   = output_q;
  assign div_zero = div_zero_q;
  assign illegal  = illegal_q;

endmodule
